// File: rtl/instr_encoder.sv
// RV32I encoder for R/load/store/branch requests with a registered output stage and word-address
// counter. Define ENC_RANGE_CHECK_EN to reject out-of-range load/store and misaligned branch immediates.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [6:0]        req_funct7_i,
    input  logic [12:0]       req_imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              err_o,
    output logic              wrapped_o
);

    typedef enum logic [1:0] {OpR, OpLoad, OpStore, OpBranch} op_e;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrMax  = '1;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic              wrapped_q, wrapped_d;

    op_e         op;
    logic [31:0] enc;
    logic        reject;
    logic        accept;
    logic        fire_out;

    assign op          = op_e'(req_op_i);
    assign req_ready_o = !out_valid_q || out_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign fire_out    = out_valid_q && out_ready_i;

    always_comb begin
        enc = '0;
        unique case (op)
            OpR: enc = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, OpcR};
            OpLoad: enc = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, OpcLoad};
            OpStore: enc = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            req_imm_i[4:0], OpcStore};
            OpBranch: enc = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                             req_imm_i[4:1], req_imm_i[11], OpcBranch};
            default: enc = '0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        reject = 1'b0;
        unique case (op)
            OpLoad, OpStore: reject = req_imm_i[12] != req_imm_i[11];
            OpBranch:        reject = req_imm_i[0];
            default:         reject = 1'b0;
        endcase
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        cnt_d       = fire_out ? cnt_q + ADDR_W'(1) : cnt_q;
        wrapped_d   = wrapped_q || (fire_out && cnt_q == AddrMax);
        err_d       = err_q || (accept && reject);
        out_valid_d = out_valid_q && !out_ready_i;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        // The new word takes the post-handshake counter value, so a reload
        // in the same cycle as a drain lands at previous address + 1.
        if (accept && !reject) begin
            out_valid_d = 1'b1;
            out_instr_d = enc;
            out_addr_d  = cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q       <= BaseAddr;
            out_addr_q  <= BaseAddr;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_addr_q  <= out_addr_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_addr_o  = out_addr_q;
    assign err_o       = err_q;
    assign wrapped_o   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder: default instance plus a narrow ADDR_W=2, BASE_ADDR=2
// instance for the wrap case.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, out_valid, out_ready, err, wrapped;
    logic [1:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [12:0] req_imm;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;

    logic        s_req_valid, s_req_ready, s_out_valid, s_err, s_wrapped;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_funct3_i(req_funct3), .req_funct7_i(req_funct7), .req_imm_i(req_imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
        .out_addr_o(out_addr), .err_o(err), .wrapped_o(wrapped)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) u_dut_small (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_op_i(2'd0),
        .req_rd_i(5'd3), .req_rs1_i(5'd1), .req_rs2_i(5'd2),
        .req_funct3_i(3'd0), .req_funct7_i(7'd0), .req_imm_i(13'd0),
        .out_valid_o(s_out_valid), .out_ready_i(1'b1), .out_instr_o(s_out_instr),
        .out_addr_o(s_out_addr), .err_o(s_err), .wrapped_o(s_wrapped)
    );

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_rd     = v.rd;
        req_rs1    = v.rs1;
        req_rs2    = v.rs2;
        req_funct3 = v.f3;
        req_funct7 = v.f7;
        req_imm    = v.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{op: 2'd0, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7: 7'd0,
                    imm: 13'h1ABC, exp: 32'h002081B3};
        vecs[1] = '{op: 2'd1, rd: 5'd5, rs1: 5'd2, rs2: 5'd9, f3: 3'd2, f7: 7'd5,
                    imm: 13'd8, exp: 32'h00812283};
        vecs[2] = '{op: 2'd2, rd: 5'd7, rs1: 5'd2, rs2: 5'd6, f3: 3'd2, f7: 7'd0,
                    imm: 13'd12, exp: 32'h00612623};
        vecs[3] = '{op: 2'd3, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7: 7'd0,
                    imm: 13'h1FFC, exp: 32'hFE208EE3};
        vecs[4] = '{op: 2'd0, rd: 5'd1, rs1: 5'd2, rs2: 5'd3, f3: 3'd0, f7: 7'h20,
                    imm: 13'd0, exp: 32'h403100B3};
        vecs[5] = '{op: 2'd1, rd: 5'd1, rs1: 5'd0, rs2: 5'd31, f3: 3'd0, f7: 7'h7F,
                    imm: 13'h1FFF, exp: 32'hFFF00083};
        vecs[6] = '{op: 2'd3, rd: 5'd9, rs1: 5'd0, rs2: 5'd0, f3: 3'd1, f7: 7'd0,
                    imm: 13'd8, exp: 32'h00001463};
        vecs[7] = '{op: 2'd2, rd: 5'd4, rs1: 5'd2, rs2: 5'd1, f3: 3'd0, f7: 7'd0,
                    imm: 13'h1FF8, exp: 32'hFE110C23};

        rst_n = 1'b0;
        req_valid = 1'b0;
        s_req_valid = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0]);
        req_valid = 1'b0;
        repeat (2) tick();

        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_instr", out_instr, 32'd0);
        check("reset_out_addr", {24'd0, out_addr}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_wrapped", {31'd0, wrapped}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_small_addr", {30'd0, s_out_addr}, 32'd2);
        rst_n = 1'b1;

        // Back-to-back encodes with out_ready held high.
        exp_addr = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            #0 check($sformatf("vec%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), {24'd0, out_addr}, 32'(exp_addr));
            exp_addr++;
        end
        req_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Output stall: word held stable and req_ready low until out_ready.
        out_ready = 1'b0;
        drive(vecs[3]);
        tick();
        req_valid = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_instr", out_instr, 32'hFE208EE3);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stall%0d_instr", k), out_instr, 32'hFE208EE3);
            check($sformatf("stall%0d_addr", k), {24'd0, out_addr}, 32'(exp_addr));
            check($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 check("unstall_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("unstall_drain", {31'd0, out_valid}, 32'd0);
        exp_addr++;

        v = vecs[3];
        v.imm = 13'd3;
        drive(v);
        tick();
`ifdef ENC_RANGE_CHECK_EN
        check("rej_branch_valid", {31'd0, out_valid}, 32'd0);
        check("rej_branch_err", {31'd0, err}, 32'd1);
        v = vecs[1];
        v.imm = 13'h0800;
        drive(v);
        tick();
        check("rej_load_valid", {31'd0, out_valid}, 32'd0);
        check("rej_load_err", {31'd0, err}, 32'd1);
        drive(vecs[0]);
        tick();
        check("post_rej_valid", {31'd0, out_valid}, 32'd1);
        check("post_rej_instr", out_instr, 32'h002081B3);
        check("post_rej_addr", {24'd0, out_addr}, 32'(exp_addr));
        exp_addr++;
`else
        check("trunc_branch_instr", out_instr, 32'h00208163);
        check("trunc_branch_addr", {24'd0, out_addr}, 32'(exp_addr));
        exp_addr++;
        v = vecs[1];
        v.imm = 13'h0800;
        drive(v);
        tick();
        check("trunc_load_instr", out_instr, 32'h80012283);
        check("trunc_load_addr", {24'd0, out_addr}, 32'(exp_addr));
        check("no_check_err", {31'd0, err}, 32'd0);
        exp_addr++;
`endif
        req_valid = 1'b0;
        tick();
        check("main_wrapped_clear", {31'd0, wrapped}, 32'd0);

        // Narrow counter: 2, 3, then wrap to 0 (not BASE_ADDR), then 1.
        s_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ea;
            logic       ew;
            ea = 2'(k + 2);
            ew = (k >= 2);
            tick();
            check($sformatf("small%0d_addr", k), {30'd0, s_out_addr}, {30'd0, ea});
            check($sformatf("small%0d_wrapped", k), {31'd0, s_wrapped}, {31'd0, ew});
            check($sformatf("small%0d_instr", k), s_out_instr, 32'h002081B3);
        end
        s_req_valid = 1'b0;
        tick();
        check("small_drain", {31'd0, s_out_valid}, 32'd0);
        check("small_err", {31'd0, s_err}, 32'd0);
        check("small_ready", {31'd0, s_req_ready}, 32'd1);

        // Reset while a word is stalled.
        out_ready = 1'b0;
        drive(vecs[4]);
        tick();
        req_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_addr", {24'd0, out_addr}, 32'd0);
        check("midrst_instr", out_instr, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_wrapped", {31'd0, wrapped}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_small_wrapped", {31'd0, s_wrapped}, 32'd0);
        check("midrst_small_addr", {30'd0, s_out_addr}, 32'd2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(vecs[2]);
        tick();
        req_valid = 1'b0;
        check("post_rst_addr", {24'd0, out_addr}, 32'd0);
        check("post_rst_instr", out_instr, 32'h00612623);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
